adder_tree_pipe: RTL and testbench

- Parametrised, pipelined N-input reduction adder for summing PE partial products in the systolic array.
- Successor to the 8×11-bit combinational tree. Generalised in lane count, lane width and signedness.
- Adds one register level per tree level, a valid/ready handshake at both ends, and optional multi-beat accumulation.
- Sits between a PE row/column output bus and the result writeback path.

---
 rtl/adder_tree_pkg.sv | 35 +++
 rtl/adder_tree_pipe_if.sv | 25 ++
 rtl/adder_tree_stage.sv | 43 ++++
 rtl/adder_tree_pipe.sv | 124 ++++++++++++
 tb/tb_adder_tree_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined reduction adder: level count, flat-vector
// offsets for the per-level partial-sum bus, and parameter sanity checks.
package adder_tree_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int tree_levels(input int n_in);
    return clog2(n_in);
  endfunction

  // Level k (k >= 1) holds n_in>>k lanes; levels are packed back to back
  // starting with level 1 at lane 0, so level k starts at n_in - 2*(n_in>>k).
  function automatic int lvl_off(input int n_in, input int k);
    return n_in - 2 * (n_in >> k);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit out_w_ok(input int n_in, input int in_w, input int out_w);
    return out_w >= in_w + tree_levels(n_in);
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Handshake bundle for adder_tree_pipe: input beat side and result side.
// The DUT uses the slave modport; the producer/consumer uses master.
interface adder_tree_pipe_if #(
  parameter int N_IN  = 8,
  parameter int IN_W  = 11,
  parameter int OUT_W = 16
);
  logic [N_IN*IN_W-1:0] in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_last;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/adder_tree_stage.sv
// One registered level of the reduction tree: N_PAIRS pairwise adds of
// already-extended OUT_W lanes, with a valid bit and a group-last tag that
// travel with the data. The stage loads whenever its advance input is high.
module adder_tree_stage #(
  parameter int N_PAIRS = 4,
  parameter int OUT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       adv,
  input  logic [2*N_PAIRS*OUT_W-1:0] in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic [N_PAIRS*OUT_W-1:0]   out_data,
  output logic                       out_valid,
  output logic                       out_last
);

  logic [N_PAIRS*OUT_W-1:0] sums;

  // Pairwise sums of adjacent lanes; lane 2p pairs with lane 2p+1.
  always_comb begin
    sums = '0;
    for (int p = 0; p < N_PAIRS; p++) begin
      sums[p*OUT_W +: OUT_W] = in_data[(2*p)*OUT_W +: OUT_W]
                             + in_data[(2*p+1)*OUT_W +: OUT_W];
    end
  end

  // Stage register: holds while stalled, otherwise takes the upstream level.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (adv) begin
      out_data  <= sums;
      out_valid <= in_valid;
      out_last  <= in_last;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined N_IN-input reduction adder with valid/ready at both ends.
// One register level per tree level, so results appear LEVELS cycles after
// the input transfer. Bubbles collapse: an empty stage loads even while the
// output is stalled.
// Build option ADDER_TREE_ACCUM_EN: accumulate tree results across beats and
// emit only on the beat tagged in_last; without it in_last is ignored.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int N_IN   = 8,
  parameter int IN_W   = 11,
  parameter int OUT_W  = 16,
  parameter int SIGNED = 0
) (
  input logic             clk,
  input logic             rst,
  adder_tree_pipe_if.slave bus
);

  localparam int LEVELS = tree_levels(N_IN);
  localparam int TREE_W = (N_IN - 1) * OUT_W;

  if (!is_pow2(N_IN)) begin : g_bad_n
    $error("adder_tree_pipe: N_IN must be a power of two and at least 2");
  end
  if (!out_w_ok(N_IN, IN_W, OUT_W)) begin : g_bad_w
    $error("adder_tree_pipe: OUT_W must be at least IN_W + clog2(N_IN)");
  end

  logic [N_IN*OUT_W-1:0] ext_data;
  logic [TREE_W-1:0]     tree_data;
  logic [LEVELS:1]       stage_v;
  logic [LEVELS:1]       stage_last;
  logic [LEVELS+1:1]     adv;
  logic                  adv_out;
  logic [OUT_W-1:0]      tree_sum;

  // Widen every lane to the full result width before any add.
  for (genvar i = 0; i < N_IN; i++) begin : g_ext
    logic [IN_W-1:0] lane;
    assign lane = bus.in_data[i*IN_W +: IN_W];
    if (SIGNED != 0) begin : g_sext
      assign ext_data[i*OUT_W +: OUT_W] = {{(OUT_W-IN_W){lane[IN_W-1]}}, lane};
    end else begin : g_zext
      assign ext_data[i*OUT_W +: OUT_W] = {{(OUT_W-IN_W){1'b0}}, lane};
    end
  end

  // Advance chain: a stage may load if it is empty or its successor advances.
  always_comb begin
    adv = '0;
    adv[LEVELS+1] = adv_out;
    for (int k = LEVELS; k >= 1; k--) begin
      adv[k] = !stage_v[k] || adv[k+1];
    end
  end

  assign bus.in_ready = adv[1];

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NP = N_IN >> k;
    logic [2*NP*OUT_W-1:0] st_in;
    logic                  st_vin;
    logic                  st_lin;

    if (k == 1) begin : g_first
      assign st_in  = ext_data;
      assign st_vin = bus.in_valid;
      assign st_lin = bus.in_last;
    end else begin : g_next
      assign st_in  = tree_data[lvl_off(N_IN, k-1)*OUT_W +: 2*NP*OUT_W];
      assign st_vin = stage_v[k-1];
      assign st_lin = stage_last[k-1];
    end

    adder_tree_stage #(
      .N_PAIRS (NP),
      .OUT_W   (OUT_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .adv       (adv[k]),
      .in_data   (st_in),
      .in_valid  (st_vin),
      .in_last   (st_lin),
      .out_data  (tree_data[lvl_off(N_IN, k)*OUT_W +: NP*OUT_W]),
      .out_valid (stage_v[k]),
      .out_last  (stage_last[k])
    );
  end

  assign tree_sum = tree_data[TREE_W-1 -: OUT_W];

`ifdef ADDER_TREE_ACCUM_EN
  logic [OUT_W-1:0] acc_q;

  // Non-last beats are absorbed into the accumulator without waiting for
  // out_ready; only the last beat of a group is presented downstream.
  assign adv_out       = !stage_last[LEVELS] || bus.out_ready;
  assign bus.out_valid = stage_v[LEVELS] && stage_last[LEVELS];
  assign bus.out_data  = acc_q + tree_sum;

  // Accumulator: add absorbed beats, clear when the group result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (stage_v[LEVELS]) begin
      if (!stage_last[LEVELS]) begin
        acc_q <= acc_q + tree_sum;
      end else if (bus.out_ready) begin
        acc_q <= '0;
      end
    end
  end
`else
  logic unused_last;

  assign adv_out       = bus.out_ready;
  assign bus.out_valid = stage_v[LEVELS];
  assign bus.out_data  = tree_sum;
  assign unused_last   = stage_last[LEVELS];
`endif

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Bench for adder_tree_pipe: an unsigned and a signed instance driven with
// identical stimulus, each checked against a lane-sum reference model.
module tb_adder_tree_pipe;

  localparam int N_IN  = 8;
  localparam int IN_W  = 11;
  localparam int OUT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  adder_tree_pipe_if #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus_u ();
  adder_tree_pipe_if #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W)) bus_s ();

  adder_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(0)) u_dut_u (
    .clk (clk), .rst (rst), .bus (bus_u)
  );
  adder_tree_pipe #(.N_IN(N_IN), .IN_W(IN_W), .OUT_W(OUT_W), .SIGNED(1)) u_dut_s (
    .clk (clk), .rst (rst), .bus (bus_s)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          n_acc   = 0;
  int          grp_u   = 0;
  int          grp_s   = 0;
  logic [15:0] exp_u[$];
  logic [15:0] exp_s[$];
  int          out_cycs[$];
  logic        last_in_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: sum of the eight lanes as plain integers, modulo 2^16.
  function automatic logic [15:0] tree_ref(input logic [87:0] d, input bit sgn);
    int s;
    s = 0;
    for (int i = 0; i < N_IN; i++) begin
      int lane;
      lane = int'(d[i*IN_W +: IN_W]);
      if (sgn && lane >= 1024) lane = lane - 2048;
      s = s + lane;
    end
    return 16'(s);
  endfunction

  task automatic model_accept(input logic [87:0] d, input logic last);
`ifdef ADDER_TREE_ACCUM_EN
    grp_u = grp_u + int'(tree_ref(d, 1'b0));
    grp_s = grp_s + int'(tree_ref(d, 1'b1));
    if (last) begin
      exp_u.push_back(16'(grp_u));
      exp_s.push_back(16'(grp_s));
      grp_u = 0;
      grp_s = 0;
    end
`else
    if (last === 1'bx) grp_u = 0;
    exp_u.push_back(tree_ref(d, 1'b0));
    exp_s.push_back(tree_ref(d, 1'b1));
`endif
  endtask

  function automatic logic [87:0] lanes_ramp(input int base);
    logic [87:0] d;
    d = '0;
    for (int i = 0; i < N_IN; i++) d[i*IN_W +: IN_W] = 11'(base + i);
    return d;
  endfunction

  function automatic logic [87:0] lanes_const(input int v);
    logic [87:0] d;
    d = '0;
    for (int i = 0; i < N_IN; i++) d[i*IN_W +: IN_W] = 11'(v);
    return d;
  endfunction

  function automatic logic [87:0] lanes_rand();
    logic [87:0] d;
    d = '0;
    for (int i = 0; i < N_IN; i++) d[i*IN_W +: IN_W] = 11'($urandom_range(0, 2047));
    return d;
  endfunction

  task automatic set_in(input logic [87:0] d, input logic v, input logic last);
    bus_u.in_data  = d;
    bus_s.in_data  = d;
    bus_u.in_valid = v;
    bus_s.in_valid = v;
    bus_u.in_last  = last;
    bus_s.in_last  = last;
  endtask

  task automatic set_ready(input logic r);
    bus_u.out_ready = r;
    bus_s.out_ready = r;
  endtask

  // One clock: sample handshakes mid-cycle, score transfers, return after edge.
  task automatic cycle();
    logic [15:0] e;
    @(negedge clk);
    last_in_ready = bus_u.in_ready;
    if (!rst && bus_u.out_valid && bus_u.out_ready) begin
      out_cycs.push_back(cyc);
      chk("sb_underrun", 32'(exp_u.size() > 0 && exp_s.size() > 0), 32'd1);
      if (exp_u.size() > 0) begin
        e = exp_u.pop_front();
        chk("sb_data_u", 32'(bus_u.out_data), 32'(e));
      end
      if (exp_s.size() > 0) begin
        e = exp_s.pop_front();
        chk("sb_data_s", 32'(bus_s.out_data), 32'(e));
      end
    end
    if (!rst && bus_u.in_valid && bus_u.in_ready) begin
      n_acc++;
      model_accept(bus_u.in_data, bus_u.in_last);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_out(input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus_u.out_valid) begin
        ok = 1'b1;
        break;
      end
      cycle();
    end
    chk("wait_out_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_beat(input logic [87:0] d, input logic last);
    int a0;
    a0 = n_acc;
    set_in(d, 1'b1, last);
    for (int i = 0; i < 20 && n_acc == a0; i++) cycle();
    chk("send_timeout", 32'(n_acc - a0), 32'd1);
    set_in(d, 1'b0, last);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] held_u;
    logic [15:0] held_s;
    bit          held_set;
    int          acc0;
    int          bad;

    // Reset state
    set_in('0, 1'b0, 1'b1);
    set_ready(1'b1);
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    chk("rst_out_valid_u", 32'(bus_u.out_valid), 32'd0);
    chk("rst_out_valid_s", 32'(bus_s.out_valid), 32'd0);
    chk("rst_out_data_u", 32'(bus_u.out_data), 32'd0);
    chk("rst_out_data_s", 32'(bus_s.out_data), 32'd0);
    chk("rst_in_ready_u", 32'(bus_u.in_ready), 32'd1);
    chk("rst_in_ready_s", 32'(bus_s.in_ready), 32'd1);
    cycle();
    chk("rst_in_ready_next", 32'(bus_u.in_ready), 32'd1);

    // Distinct lanes 1..8: exact latency of three edges, sum 36
    set_in(lanes_ramp(1), 1'b1, 1'b1);
    cycle();
    set_in('0, 1'b0, 1'b1);
    chk("lat_valid_e1", 32'(bus_u.out_valid), 32'd0);
    cycle();
    chk("lat_valid_e2", 32'(bus_u.out_valid), 32'd0);
    cycle();
    chk("lat_valid_e3", 32'(bus_u.out_valid), 32'd1);
    chk("lanes_1to8_u", 32'(bus_u.out_data), 32'd36);
    chk("lanes_1to8_s", 32'(bus_s.out_data), 32'd36);
    cycle();

    // All lanes at maximum code: 16376 unsigned, -8 signed
    set_in(lanes_const(2047), 1'b1, 1'b1);
    cycle();
    set_in('0, 1'b0, 1'b1);
    wait_out(10);
    chk("max_lanes_u", 32'(bus_u.out_data), 32'd16376);
    chk("max_lanes_s", 32'(bus_s.out_data), 32'hFFF8);
    cycle();

    // Ten back-to-back beats: in_ready stays high, ten gap-free results
    out_cycs.delete();
    for (int b = 0; b < 10; b++) begin
      set_in(lanes_ramp(b), 1'b1, 1'b1);
      cycle();
      chk("b2b_in_ready", 32'(last_in_ready), 32'd1);
    end
    set_in('0, 1'b0, 1'b1);
    repeat (4) cycle();
    chk("b2b_count", 32'(out_cycs.size()), 32'd10);
    if (out_cycs.size() == 10) chk("b2b_no_gaps", 32'(out_cycs[9] - out_cycs[0]), 32'd9);

    // Stall from an empty pipe: three beats fit, output held stable
    set_ready(1'b0);
    acc0 = n_acc;
    held_set = 1'b0;
    held_u = '0;
    held_s = '0;
    for (int s = 0; s < 6; s++) begin
      set_in(lanes_rand(), 1'b1, 1'b1);
      cycle();
      if (bus_u.out_valid) begin
        if (!held_set) begin
          held_u = bus_u.out_data;
          held_s = bus_s.out_data;
          held_set = 1'b1;
        end else begin
          chk("stall_stable_u", 32'(bus_u.out_data), 32'(held_u));
          chk("stall_stable_s", 32'(bus_s.out_data), 32'(held_s));
        end
      end
    end
    chk("stall_accepted", 32'(n_acc - acc0), 32'd3);
    chk("stall_in_ready", 32'(bus_u.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus_u.out_valid), 32'd1);
    set_ready(1'b1);
    for (int s = 0; s < 4; s++) begin
      set_in(lanes_rand(), 1'b1, 1'b1);
      cycle();
    end
    set_in('0, 1'b0, 1'b1);
    repeat (6) cycle();
    chk("stall_drained_u", 32'(exp_u.size()), 32'd0);
    chk("stall_drained_s", 32'(exp_s.size()), 32'd0);

    // Reset with two beats in flight: they must never appear
    for (int s = 0; s < 2; s++) begin
      set_in(lanes_rand(), 1'b1, 1'b1);
      cycle();
    end
    set_in('0, 1'b0, 1'b1);
    rst = 1'b1;
    cycle();
    chk("midrst_out_valid_u", 32'(bus_u.out_valid), 32'd0);
    chk("midrst_out_valid_s", 32'(bus_s.out_valid), 32'd0);
    exp_u.delete();
    exp_s.delete();
    grp_u = 0;
    grp_s = 0;
    rst = 1'b0;
    bad = 0;
    for (int s = 0; s < 5; s++) begin
      cycle();
      if (bus_u.out_valid || bus_s.out_valid) bad++;
    end
    chk("midrst_no_ghost", 32'(bad), 32'd0);
    set_in(lanes_const(1), 1'b1, 1'b1);
    cycle();
    set_in('0, 1'b0, 1'b1);
    wait_out(10);
    chk("post_rst_ones_u", 32'(bus_u.out_data), 32'd8);
    chk("post_rst_ones_s", 32'(bus_s.out_data), 32'd8);
    cycle();

`ifdef ADDER_TREE_ACCUM_EN
    // Group of three all-ones beats absorbed without out_ready, then 24
    set_ready(1'b0);
    send_beat(lanes_const(1), 1'b0);
    send_beat(lanes_const(1), 1'b0);
    send_beat(lanes_const(1), 1'b1);
    wait_out(10);
    chk("accum_group_u", 32'(bus_u.out_data), 32'd24);
    chk("accum_group_s", 32'(bus_s.out_data), 32'd24);
    set_ready(1'b1);
    cycle();
    // Single-beat group of all-twos: accumulator must have cleared
    send_beat(lanes_const(2), 1'b1);
    wait_out(10);
    chk("accum_cleared_u", 32'(bus_u.out_data), 32'd16);
    chk("accum_cleared_s", 32'(bus_s.out_data), 32'd16);
    cycle();
`else
    // in_last low still yields a result for the beat
    send_beat(lanes_const(2), 1'b0);
    wait_out(10);
    chk("last_ignored_u", 32'(bus_u.out_data), 32'd16);
    chk("last_ignored_s", 32'(bus_s.out_data), 32'd16);
    cycle();
`endif

    // Randomised traffic with random backpressure
    for (int s = 0; s < 300; s++) begin
      set_in(lanes_rand(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      set_ready(1'($urandom_range(0, 2) != 0));
      cycle();
    end
    set_ready(1'b1);
    send_beat(lanes_rand(), 1'b1);
    set_in('0, 1'b0, 1'b1);
    repeat (8) cycle();
    chk("rand_drained_u", 32'(exp_u.size()), 32'd0);
    chk("rand_drained_s", 32'(exp_s.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
